// File: rtl/xadac_exe_arb.sv
// Round-robin arbiter sharing one vector execute unit; in-order response routing (id check: XADAC_ARB_ID_CHECK_EN).
// Latency: request and response paths are combinational (zero cycles); err_o registers one cycle after the response.
// Backpressure: a stalled grant is locked until accepted; issue stops at Depth outstanding; response ready follows the head owner.
module xadac_exe_arb #(
    parameter int NumReq    = 2,
    parameter int DataWidth = 128,
    parameter int IdWidth   = 4,
    parameter int Depth     = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq*32-1:0]            req_instr_i,
    input  logic [NumReq*3*DataWidth-1:0]   req_vs_i,
    input  logic [NumReq*IdWidth-1:0]       req_id_i,
    output logic [NumReq-1:0]               rsp_valid_o,
    input  logic [NumReq-1:0]               rsp_ready_i,
    output logic [4:0]                      rsp_vd_addr_o,
    output logic [DataWidth-1:0]            rsp_vd_data_o,
    output logic [IdWidth-1:0]              rsp_id_o,
    output logic                            dn_req_valid_o,
    input  logic                            dn_req_ready_i,
    output logic [31:0]                     dn_instr_o,
    output logic [3*DataWidth-1:0]          dn_vs_o,
    output logic [IdWidth-1:0]              dn_id_o,
    input  logic                            dn_rsp_valid_i,
    output logic                            dn_rsp_ready_o,
    input  logic [4:0]                      dn_rsp_vd_addr_i,
    input  logic [DataWidth-1:0]            dn_rsp_vd_data_i,
    input  logic [IdWidth-1:0]              dn_rsp_id_i,
    output logic                            err_o
);

    localparam int GW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    localparam logic [GW-1:0] LAST_REQ  = GW'(NumReq - 1);
    localparam logic [PW-1:0] LAST_SLOT = PW'(Depth - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(Depth);

    logic              state;
    logic [GW-1:0]     ptr;
    logic [GW-1:0]     lock_gnt;
    logic [GW-1:0]     rr_gnt;
    logic [GW-1:0]     gnt;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [GW-1:0]     fifo_gnt [Depth];
    logic [GW-1:0]     head_gnt;
    logic              fifo_empty;
    logic              req_hs;
    logic              rsp_hs;
    logic [2*NumReq-1:0] rot_vld;

    // Rotate valids so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin : rr_search
        int sel;
        sel     = 0;
        rr_gnt  = ptr;
        rot_vld = {req_valid_i, req_valid_i} >> ptr;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (rot_vld[i]) begin
                sel = int'(ptr) + i;
                if (sel >= NumReq) sel = sel - NumReq;
                rr_gnt = GW'(sel);
            end
        end
    end

    assign gnt        = (state == ST_LOCKED) ? lock_gnt : rr_gnt;
    assign fifo_empty = (cnt == '0);
    assign head_gnt   = fifo_gnt[rd_ptr];

    assign dn_req_valid_o = !rst && (|req_valid_i) && (cnt != FULL_CNT);
    assign req_hs         = dn_req_valid_o && dn_req_ready_i;
    assign dn_instr_o     = req_instr_i[gnt*32 +: 32];
    assign dn_vs_o        = req_vs_i[gnt*(3*DataWidth) +: 3*DataWidth];
    assign dn_id_o        = req_id_i[gnt*IdWidth +: IdWidth];

    assign dn_rsp_ready_o = !rst && !fifo_empty && rsp_ready_i[head_gnt];
    assign rsp_hs         = dn_rsp_valid_i && dn_rsp_ready_o;
    assign rsp_vd_addr_o  = dn_rsp_vd_addr_i;
    assign rsp_vd_data_o  = dn_rsp_vd_data_i;
    assign rsp_id_o       = dn_rsp_id_i;

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_ready_o[i] = req_hs && (gnt == GW'(i));
            rsp_valid_o[i] = !rst && dn_rsp_valid_i && !fifo_empty && (head_gnt == GW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            lock_gnt <= '0;
            cnt      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (dn_req_valid_o && !dn_req_ready_i) begin
                    state    <= ST_LOCKED;
                    lock_gnt <= gnt;
                end
            end else if (req_hs) begin
                state <= ST_IDLE;
            end
            if (req_hs) begin
                ptr    <= (gnt == LAST_REQ) ? '0 : gnt + 1'b1;
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            end
            if (rsp_hs) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            end
            if (req_hs && !rsp_hs) begin
                cnt <= cnt + 1'b1;
            end else if (!req_hs && rsp_hs) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) fifo_gnt[wr_ptr] <= gnt;
    end

`ifdef XADAC_ARB_ID_CHECK_EN
    logic [IdWidth-1:0] fifo_id [Depth];
    logic               err_q;

    always_ff @(posedge clk) begin
        if (req_hs) fifo_id[wr_ptr] <= dn_id_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (rsp_hs && (dn_rsp_id_i != fifo_id[rd_ptr])) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_xadac_exe_arb.sv
// Bench for xadac_exe_arb: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations on the DUT grant order, backpressure, routing and reset.
module tb_xadac_exe_arb;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int IW = 4;
    localparam int D  = 4;
`ifdef XADAC_ARB_ID_CHECK_EN
    localparam bit IDCHK = 1'b1;
`else
    localparam bit IDCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]        req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [N*32-1:0]     req_instr_i;
    logic [N*3*DW-1:0]   req_vs_i;
    logic [N*IW-1:0]     req_id_i;
    logic [4:0]          rsp_vd_addr_o, dn_rsp_vd_addr_i;
    logic [DW-1:0]       rsp_vd_data_o, dn_rsp_vd_data_i;
    logic [IW-1:0]       rsp_id_o, dn_id_o, dn_rsp_id_i;
    logic                dn_req_valid_o, dn_req_ready_i, dn_rsp_valid_i, dn_rsp_ready_o, err_o;
    logic [31:0]         dn_instr_o;
    logic [3*DW-1:0]     dn_vs_o;

    logic [31:0]   instr [N];
    logic [3*DW-1:0] vs  [N];
    logic [IW-1:0] id    [N];

    always_comb begin
        for (int r = 0; r < N; r++) begin
            req_instr_i[r*32 +: 32]     = instr[r];
            req_vs_i[r*3*DW +: 3*DW]    = vs[r];
            req_id_i[r*IW +: IW]        = id[r];
        end
    end

    xadac_exe_arb #(.NumReq(N), .DataWidth(DW), .IdWidth(IW), .Depth(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_instr_i(req_instr_i), .req_vs_i(req_vs_i), .req_id_i(req_id_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_vd_addr_o(rsp_vd_addr_o), .rsp_vd_data_o(rsp_vd_data_o), .rsp_id_o(rsp_id_o),
        .dn_req_valid_o(dn_req_valid_o), .dn_req_ready_i(dn_req_ready_i),
        .dn_instr_o(dn_instr_o), .dn_vs_o(dn_vs_o), .dn_id_o(dn_id_o),
        .dn_rsp_valid_i(dn_rsp_valid_i), .dn_rsp_ready_o(dn_rsp_ready_o),
        .dn_rsp_vd_addr_i(dn_rsp_vd_addr_i), .dn_rsp_vd_data_i(dn_rsp_vd_data_i),
        .dn_rsp_id_i(dn_rsp_id_i), .err_o(err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: outstanding transactions in order, rotating priority, stall lock.
    typedef struct { int idx; int tid; } ent_t;
    ent_t q[$];
    int   m_ptr = 0;
    bit   m_lock = 1'b0;
    int   m_lgnt = 0;
    bit   m_err = 1'b0;
    int   dlog[$];

    function automatic int dl(input int i);
        return (i < dlog.size()) ? dlog[i] : -1;
    endfunction

    always @(negedge clk) begin : model
        int  g, hd, c;
        bit  dnv;
        if (rst) begin
            chk("rst_req_ready", req_ready_o, 0);
            chk("rst_dn_req_valid", dn_req_valid_o, 0);
            chk("rst_rsp_valid", rsp_valid_o, 0);
            chk("rst_dn_rsp_ready", dn_rsp_ready_o, 0);
            q.delete();
            m_ptr = 0; m_lock = 1'b0; m_err = 1'b0;
        end else begin
            g = -1;
            if (m_lock) begin
                g = m_lgnt;
            end else begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (g < 0 && req_valid_i[c]) g = c;
                end
            end
            dnv = (req_valid_i != 0) && (q.size() < D);
            chk("dn_req_valid", dn_req_valid_o, dnv);
            if (dnv) begin
                chk("dn_instr", dn_instr_o, instr[g]);
                chk("dn_vs", dn_vs_o, vs[g]);
                chk("dn_id", dn_id_o, id[g]);
            end
            chk("req_ready", req_ready_o, (dnv && dn_req_ready_i) ? (1 << g) : 0);
            hd = (q.size() > 0) ? q[0].idx : -1;
            chk("rsp_valid", rsp_valid_o, (hd >= 0 && dn_rsp_valid_i) ? (1 << hd) : 0);
            chk("dn_rsp_ready", dn_rsp_ready_o, (hd >= 0) ? rsp_ready_i[hd] : 1'b0);
            chk("rsp_vd_addr", rsp_vd_addr_o, dn_rsp_vd_addr_i);
            chk("rsp_vd_data", rsp_vd_data_o, dn_rsp_vd_data_i);
            chk("rsp_id", rsp_id_o, dn_rsp_id_i);
            chk("err", err_o, m_err);
            for (int k = 0; k < N; k++) if (req_ready_o[k]) dlog.push_back(k);
            if (hd >= 0 && dn_rsp_valid_i && rsp_ready_i[hd]) begin
                if (IDCHK && (int'(dn_rsp_id_i) != q[0].tid)) m_err = 1'b1;
                void'(q.pop_front());
            end
            if (dnv && dn_req_ready_i) begin
                q.push_back('{idx: g, tid: int'(id[g])});
                m_ptr  = (g + 1) % N;
                m_lock = 1'b0;
            end else if (dnv) begin
                m_lock = 1'b1;
                m_lgnt = g;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid_i = '0;
        rsp_ready_i = '1;
        for (int k = 0; k < 3 * D; k++) begin
            if (q.size() == 0) break;
            dn_rsp_valid_i = 1'b1;
            dn_rsp_id_i    = IW'(q[0].tid);
            cyc();
        end
        dn_rsp_valid_i = 1'b0;
        #1 chk("drained_empty", dn_rsp_ready_o, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = '1; dn_req_ready_i = 1'b1; rsp_ready_i = '1;
        dn_rsp_valid_i = 1'b1; dn_rsp_id_i = '0;
        dn_rsp_vd_addr_i = 5'd9; dn_rsp_vd_data_i = 16'hBEEF;
        for (int r = 0; r < N; r++) begin
            instr[r] = 32'hA000_0000 + 32'(r);
            vs[r]    = {16'h1111 * 16'(r + 1), 16'h0F0F ^ 16'(r), 16'h8000 + 16'(r)};
            id[r]    = IW'(r + 1);
        end
        #1 chk("rst_lit_dn_vld", dn_req_valid_o, 0);
        chk("rst_lit_rsp_vld", rsp_valid_o, 0);
        cyc(); cyc();
        rst = 1'b0; req_valid_i = '0; dn_rsp_valid_i = 1'b0;
        #1 chk("idle_dn_vld", dn_req_valid_o, 0);

        // Both valid, ready always: alternate 0,1,0,1
        dlog.delete();
        req_valid_i = 2'b11;
        #1 chk("rr_first_id", dn_id_o, 1);
        repeat (4) cyc();
        req_valid_i = '0;
        chk("rr_n", dlog.size(), 4);
        chk("rr_g0", dl(0), 0); chk("rr_g1", dl(1), 1);
        chk("rr_g2", dl(2), 0); chk("rr_g3", dl(3), 1);
        drain();

        // Move ptr to 1, then stall req0 and raise req1: lock keeps req0
        dlog.delete();
        id[0] = 4'd4;
        req_valid_i = 2'b01; cyc();
        dn_req_ready_i = 1'b0; cyc();
        req_valid_i = 2'b11; cyc();
        #1 chk("lock_id", dn_id_o, 4);
        chk("lock_no_ready", req_ready_o, 0);
        cyc();
        dn_req_ready_i = 1'b1;
        #1 chk("lock_release", req_ready_o, 2'b01);
        cyc();
        req_valid_i = 2'b10;
        #1 chk("after_lock", req_ready_o, 2'b10);
        cyc();
        req_valid_i = '0;
        chk("lock_n", dlog.size(), 3);
        chk("lock_g0", dl(0), 0); chk("lock_g1", dl(1), 0); chk("lock_g2", dl(2), 1);
        drain();

        // Depth limit: 4 issues, pop at full does not issue, next cycle does
        dlog.delete();
        req_valid_i = 2'b01;
        repeat (6) cyc();
        chk("full_n", dlog.size(), 4);
        chk("full_vld", dn_req_valid_o, 0);
        dn_rsp_valid_i = 1'b1; dn_rsp_id_i = id[0]; rsp_ready_i = '1;
        #1 chk("full_pop_vld", dn_req_valid_o, 0);
        chk("full_pop_rdy", dn_rsp_ready_o, 1);
        cyc();
        dn_rsp_valid_i = 1'b0;
        #1 chk("refill_vld", dn_req_valid_o, 1);
        cyc();
        req_valid_i = '0;
        chk("refill_n", dlog.size(), 5);
        drain();

        // In-order routing: id 3 from req1, id 7 from req0
        id[1] = 4'd3; id[0] = 4'd7;
        req_valid_i = 2'b10; cyc();
        req_valid_i = 2'b01; cyc();
        req_valid_i = '0;
        dn_rsp_valid_i = 1'b1; dn_rsp_id_i = 4'd3; rsp_ready_i = 2'b01;
        #1 chk("route_first", rsp_valid_o, 2'b10);
        chk("route_stall", dn_rsp_ready_o, 0);
        cyc();
        rsp_ready_i = 2'b11;
        #1 chk("route_go", dn_rsp_ready_o, 1);
        chk("route_id3", rsp_id_o, 3);
        cyc();
        dn_rsp_id_i = 4'd7;
        #1 chk("route_second", rsp_valid_o, 2'b01);
        cyc();
        #1 chk("stray_rdy", dn_rsp_ready_o, 0);
        chk("stray_vld", rsp_valid_o, 0);
        cyc();
        dn_rsp_valid_i = 1'b0;

        // Id mismatch: issue 5, respond 6
        id[0] = 4'd5;
        req_valid_i = 2'b01; cyc();
        req_valid_i = '0;
        dn_rsp_valid_i = 1'b1; dn_rsp_id_i = 4'd6;
        cyc();
        dn_rsp_valid_i = 1'b0;
        chk("err_set", err_o, IDCHK);
        repeat (3) cyc();
        chk("err_hold", err_o, IDCHK);

        // Reset with two outstanding
        req_valid_i = 2'b11; cyc(); cyc();
        req_valid_i = 2'b11; dn_rsp_valid_i = 1'b1; rst = 1'b1;
        #1 chk("rst2_dn_vld", dn_req_valid_o, 0);
        chk("rst2_req_rdy", req_ready_o, 0);
        chk("rst2_rsp_vld", rsp_valid_o, 0);
        chk("rst2_dn_rsp_rdy", dn_rsp_ready_o, 0);
        cyc();
        rst = 1'b0; req_valid_i = '0;
        #1 chk("post_rst_err", err_o, 0);
        chk("post_rst_empty", dn_rsp_ready_o, 0);
        chk("post_rst_rsp_vld", rsp_valid_o, 0);
        dn_rsp_valid_i = 1'b0; req_valid_i = 2'b11;
        #1 chk("post_rst_grant", req_ready_o, 2'b01);
        cyc();
        drain();

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
